// File: rtl/btn_arb_pkg.sv
// btn_arb_pkg: shared state type and limits for the button event arbiter
package btn_arb_pkg;
  localparam int BTN_ARB_MAX_N = 16;
  localparam int BTN_ARB_DEFAULT_REPEAT = 16;
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} btn_arb_state_t;
endpackage

// File: rtl/btn_event_arbiter_rr_picker.sv
// rr_picker: round-robin priority encoder, first set bit at or after ptr+1 wins
module rr_picker #(
  parameter int N_BTN = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_BTN-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] j;
  always_comb begin
    any = |req;
    idx = '0;
    j = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      j = IDX_W'((int'(ptr) + k) % N_BTN);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: serializes button presses into a valid/ready event stream
// Optional hold-to-repeat events when BTN_ARB_AUTOREPEAT_EN is defined.
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int IDX_W = 2,
  parameter int REPEAT_CYCLES = BTN_ARB_DEFAULT_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] pending_out,
  output logic             overflow
);
  if (N_BTN < 2 || N_BTN > BTN_ARB_MAX_N || IDX_W != $clog2(N_BTN) || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("btn_event_arbiter: illegal parameter combination");
  end
  btn_arb_state_t   state_q, state_d;
  logic [N_BTN-1:0] prev_q, pending_q, pending_d, rise, post, gnt_mask;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic             pick_any, grant, ovf_q, ovf_d;
  assign rise = btn_level & ~prev_q;
`ifdef BTN_ARB_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_CYCLES);
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] rep;
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rep[i] = btn_level[i] && cnt_q[i] == CNT_W'(REPEAT_CYCLES - 1);
      cnt_d[i] = (!btn_level[i] || rise[i] || rep[i]) ? '0 : cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) cnt_q[i] <= reset ? '0 : cnt_d[i];
  end
  assign post = rise | rep;
`else
  assign post = rise;
`endif
  rr_picker #(.N_BTN(N_BTN), .IDX_W(IDX_W)) u_pick (
    .req(pending_q),
    .ptr(ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );
  // A new press on a button being granted this edge re-arms it instead of overflowing.
  always_comb begin
    grant = pick_any & ((state_q == IDLE) | evt_ready);
    gnt_mask = grant ? ({{(N_BTN-1){1'b0}}, 1'b1} << pick_idx) : '0;
    pending_d = (pending_q & ~gnt_mask) | post;
    ovf_d = |(post & pending_q & ~gnt_mask);
    ptr_d = grant ? pick_idx : ptr_q;
    idx_d = grant ? pick_idx : idx_q;
    state_d = grant ? OFFER : (evt_ready ? IDLE : state_q);
  end
  always_ff @(posedge clk) begin
    prev_q <= btn_level;
    if (reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      ptr_q <= IDX_W'(N_BTN - 1);
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end
  assign evt_valid = (state_q == OFFER);
  assign evt_idx = idx_q;
  assign pending_out = pending_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed and random checks against a behavioural model
module tb_btn_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  localparam int R = 16;
  logic clk = 0, reset = 1, evt_ready = 0, evt_valid, overflow;
  logic [N-1:0] btn_level = '0, pending_out;
  logic [W-1:0] evt_idx;
  int total = 0, passed = 0, cyc = 0, ovf_cnt = 0, o0, r0;
  int ev_idx[$], ev_cyc[$];
  bit m_prev[N], m_pend[N], m_valid, m_ovf;
  int m_ptr, m_idx, m_cnt[N];

  btn_event_arbiter #(.N_BTN(N), .IDX_W(W), .REPEAT_CYCLES(R)) dut (
    .clk(clk),
    .reset(reset),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_idx(evt_idx),
    .evt_ready(evt_ready),
    .pending_out(pending_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pend_vec();
    int v = 0;
    for (int i = 0; i < N; i++) v |= int'(m_pend[i]) << i;
    return v;
  endfunction

  function automatic int ev(int i);
    return i < ev_idx.size() ? ev_idx[i] : -1;
  endfunction

  function automatic int gap(int i);
    return i + 1 < ev_cyc.size() ? ev_cyc[i+1] - ev_cyc[i] : -1;
  endfunction

  // Reference: set of pending presses, one offered slot, rotating priority.
  task automatic model_step();
    bit req[N];
    bit acc;
    int g;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = btn_level[i];
        m_pend[i] = 0;
        m_cnt[i] = 0;
      end
      m_valid = 0;
      m_idx = 0;
      m_ovf = 0;
      m_ptr = N - 1;
      return;
    end
    for (int i = 0; i < N; i++) req[i] = btn_level[i] && !m_prev[i];
`ifdef BTN_ARB_AUTOREPEAT_EN
    for (int i = 0; i < N; i++) begin
      if (!btn_level[i] || req[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == R - 1) begin
        req[i] = 1;
        m_cnt[i] = 0;
      end else m_cnt[i]++;
    end
`endif
    acc = m_valid && evt_ready;
    g = -1;
    if (!m_valid || acc)
      for (int k = 1; k <= N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    m_ovf = 0;
    for (int i = 0; i < N; i++) if (req[i] && m_pend[i] && i != g) m_ovf = 1;
    if (g >= 0) begin
      m_pend[g] = 0;
      m_ptr = g;
      m_idx = g;
      m_valid = 1;
    end else if (acc) m_valid = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) m_pend[i] = 1;
      m_prev[i] = btn_level[i];
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset && evt_valid && evt_ready) begin
      ev_idx.push_back(int'(evt_idx));
      ev_cyc.push_back(cyc);
    end
    model_step();
    #1;
    check("evt_valid", int'(evt_valid), int'(m_valid));
    check("evt_idx", int'(evt_idx), m_idx);
    check("pending_out", int'(pending_out), pend_vec());
    check("overflow", int'(overflow), int'(m_ovf));
    if (overflow) ovf_cnt++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_ev();
    ev_idx.delete();
    ev_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1;
    tick(2);
    reset = 0;
    clear_ev();
  endtask

  initial begin
    tick(3);
    reset = 0;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_pending", int'(pending_out), 0);
    check("rst_ovf", int'(overflow), 0);
    // single press
    clear_ev();
    evt_ready = 1;
    btn_level = 4'b0100;
    r0 = cyc + 1;
    tick(1);
    check("single_pend", int'(pending_out), 4);
    check("single_v0", int'(evt_valid), 0);
    tick(1);
    check("single_v1", int'(evt_valid), 1);
    check("single_idx", int'(evt_idx), 2);
    tick(1);
    check("single_v2", int'(evt_valid), 0);
    check("single_pend_clr", int'(pending_out), 0);
    check("single_n", ev_idx.size(), 1);
    check("single_lat", ev_cyc.size() > 0 ? ev_cyc[0] - r0 : -1, 2);
    // simultaneous bursts
    btn_level = '0;
    do_reset();
    btn_level = 4'b1011;
    tick(6);
    check("sim_n", ev_idx.size(), 3);
    check("sim_e0", ev(0), 0);
    check("sim_e1", ev(1), 1);
    check("sim_e2", ev(2), 3);
    check("sim_gap0", gap(0), 1);
    check("sim_gap1", gap(1), 1);
    btn_level = '0;
    tick(3);
    clear_ev();
    btn_level = 4'b1011;
    tick(6);
    check("sim2_n", ev_idx.size(), 3);
    check("sim2_e0", ev(0), 0);
    check("sim2_e1", ev(1), 1);
    check("sim2_e2", ev(2), 3);
    // backpressure
    btn_level = '0;
    evt_ready = 0;
    tick(2);
    clear_ev();
    btn_level = 4'b0010;
    tick(2);
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", int'(evt_valid), 1);
      check("bp_idx", int'(evt_idx), 1);
      tick(1);
    end
    evt_ready = 1;
    tick(1);
    check("bp_drop", int'(evt_valid), 0);
    check("bp_n", ev_idx.size(), 1);
    check("bp_e0", ev(0), 1);
    // overflow
    evt_ready = 0;
    btn_level = '0;
    tick(1);
    clear_ev();
    o0 = ovf_cnt;
    btn_level = 4'b0010;
    tick(3);
    check("ovf_offer_idx", int'(evt_idx), 1);
    btn_level = 4'b1010;
    tick(2);
    check("ovf_pend", int'(pending_out), 8);
    btn_level = 4'b0010;
    tick(1);
    btn_level = 4'b1010;
    tick(2);
    check("ovf_pulses", ovf_cnt - o0, 1);
    evt_ready = 1;
    tick(5);
    check("ovf_n", ev_idx.size(), 2);
    check("ovf_e0", ev(0), 1);
    check("ovf_e1", ev(1), 3);
    check("ovf_pend_clr", int'(pending_out), 0);
    // button held through reset, then reset while offering
    btn_level = 4'b0001;
    do_reset();
    evt_ready = 1;
    tick(10);
    check("held_n", ev_idx.size(), 0);
    check("held_pend", int'(pending_out), 0);
    evt_ready = 0;
    btn_level = 4'b0101;
    tick(3);
    check("mid_valid", int'(evt_valid), 1);
    check("mid_idx", int'(evt_idx), 2);
    reset = 1;
    @(posedge clk);
    #2;
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_pend", int'(pending_out), 0);
    @(negedge clk);
    reset = 0;
    // long hold
    btn_level = '0;
    do_reset();
    evt_ready = 1;
    btn_level = 4'b0100;
    r0 = cyc + 1;
    tick(40);
    btn_level = '0;
    tick(5);
    check("hold_e0", ev(0), 2);
    check("hold_lat", ev_cyc.size() > 0 ? ev_cyc[0] - r0 : -1, 2);
`ifdef BTN_ARB_AUTOREPEAT_EN
    check("hold_n", ev_idx.size(), 3);
    check("hold_gap0", gap(0), 16);
    check("hold_gap1", gap(1), 16);
`else
    check("hold_n", ev_idx.size(), 1);
`endif
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) btn_level[i] = ~btn_level[i];
      evt_ready = $urandom_range(0, 9) < 7;
      reset = $urandom_range(0, 199) == 0;
      tick(1);
    end
    reset = 0;
    evt_ready = 1;
    btn_level = '0;
    tick(10);
    check("drain_valid", int'(evt_valid), 0);
    check("drain_pend", int'(pending_out), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Converts N debounced button levels into a single serialized stream of press events. It sits between the bank of `generic_debounce` instances and the command consumer, such as the mode/menu controller. Each rising edge becomes one pending request. Pending requests are granted round-robin and offered one at a time over a valid/ready handshake, so the consumer never misses simultaneous presses.

## Interface
- `N_BTN`, default 4: number of buttons; legal range 2–16.
- `IDX_W`, default 2: index width; must equal clog2(N_BTN).
- `REPEAT_CYCLES`, default 16: hold time before an auto-repeat event. Used only with `BTN_ARB_AUTOREPEAT_EN`; must be ≥ 2.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `btn_level`, in, N_BTN: debounced button levels, already synchronous to `clk`.
- `evt_valid`, out, 1: an event is offered.
- `evt_idx`, out, IDX_W: index of the offered button.
- `evt_ready`, in, 1: the consumer accepts the event when `evt_valid` and `evt_ready` are both high at a clock edge.
- `pending_out`, out, N_BTN: pending request bits, for debug and LEDs.
- `overflow`, out, 1: one-cycle pulse when a press is dropped.

## Operation
- Edge detect: `prev` register per button; `rise = btn_level & ~prev`.
- Reset, `reset` = 1:
  - `prev` loads `btn_level`, so a button held across reset produces no event.
  - `pending`, `evt_valid`, `evt_idx` and `overflow` are cleared to 0.
  - The round-robin pointer `ptr` is set to N_BTN-1.
  - The state machine goes to IDLE.
- Pending bits:
  - `rise[i]` sets `pending[i]`.
  - A grant of button i clears `pending[i]`.
  - If `rise[i]` arrives while `pending[i]` is already 1 and i is not being granted in that cycle, the press is dropped and `overflow` pulses for 1 cycle.
  - If a grant of i and `rise[i]` happen in the same cycle, `pending[i]` stays 1 (new event) and there is no overflow.
- Round-robin pick: search `pending` starting at `ptr+1` and wrap modulo N_BTN; the first set bit wins. A grant loads `ptr` with the granted index.
- State machine, 2 states:
  - IDLE: `evt_valid` = 0. If any pending bit is set, grant the picked index: load `evt_idx`, clear its pending bit, update `ptr`, and go to OFFER.
  - OFFER: `evt_valid` = 1, and `evt_idx` is held stable until accepted. On accept, if another pending bit is set, grant the next one in the same edge and stay in OFFER (back-to-back). Otherwise go to IDLE.
- `evt_valid` never drops without an accept, except on reset.
- Reset mid-offer: the offered event and all pending events are discarded.

## Timing
- Press latency:
  - `btn_level[i]` is first sampled high at edge k, so `pending[i]` = 1 after edge k.
  - The grant happens at edge k+1, so `evt_valid` = 1 after edge k+1.
  - Total: 2 cycles.
- Throughput: 1 event per cycle while `evt_ready` is held high and requests are pending.
- `pending_out` is a registered copy with no added latency; it equals the internal `pending`.
- `overflow` is asserted in the cycle after the dropped edge is sampled.

## Configuration
- `BTN_ARB_AUTOREPEAT_EN` defined:
  - Each button has a hold counter, width clog2(REPEAT_CYCLES), cleared while its level is 0 and on `rise`.
  - The counter increments while the level is 1.
  - At REPEAT_CYCLES-1 it posts a request exactly like a rise (same pending/overflow rules) and wraps to 0.
  - A button held from its rise therefore produces events at rise plus every REPEAT_CYCLES cycles.
- Undefined: no counters are instantiated; only rising edges generate events. `REPEAT_CYCLES` is ignored.

## Structure
- Package `btn_arb_pkg` holds:
  - the state typedef `btn_arb_state_t` (IDLE, OFFER);
  - the constants `BTN_ARB_MAX_N` = 16 and `BTN_ARB_DEFAULT_REPEAT` = 16.
- Sub-module `rr_picker`: combinational round-robin priority encoder.
  - Inputs: `req[N_BTN]`, `ptr[IDX_W]`.
  - Outputs: `any`, `idx`.
  - It is the only combinational search.

## Test plan
- Single press: after reset, raise `btn_level[2]` with `evt_ready` = 1. `evt_valid` rises 2 cycles later with `evt_idx` = 2 for exactly 1 cycle; `pending_out` returns to 0.
- Simultaneous: with `btn_level` going 0000 → 1011 and `evt_ready` = 1, expect consecutive events with idx 0, 1, 3 on back-to-back cycles. A second burst after all are released and re-pressed starts at 0 again (`ptr` = 3).
- Backpressure: with `evt_ready` = 0, press button 1. `evt_valid` and `evt_idx` = 1 stay stable for 10 cycles. Raise `evt_ready`; the event is accepted once and `evt_valid` drops.
- Overflow: with `evt_ready` = 0, button 1 is offered and button 3 is pending. Release and re-press button 3; `overflow` pulses once and only 2 events are eventually delivered.
- Reset: with button 0 held high through reset, no event appears after reset. Reset asserted while in OFFER clears `evt_valid` on the next edge.
- Autorepeat (macro on, REPEAT_CYCLES = 16): hold button 2 for 40 cycles with `evt_ready` = 1. Expect 3 events, at cycles 2, 18 and 34 after the rise. With the macro off, expect 1 event.
